traffic_timer: RTL and testbench
================================

TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clock cycles per one-second tick (minimum 2).
REQ-002 Parameter G_DEFAULT, default 8'd30, green duration in seconds after reset.
REQ-003 Parameter Y_DEFAULT, default 8'd3, yellow duration in seconds after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 count_g  input  1  green-phase count request from the traffic controller.
REQ-007 count_y  input  1  yellow-phase count request from the traffic controller.
REQ-008 cfg_we  input  1  duration-register write strobe.
REQ-009 cfg_sel  input  1  write target: 0 = green duration, 1 = yellow duration.
REQ-010 cfg_data  input  8  new duration in seconds.
REQ-011 count_done_g  output  1  one-cycle pulse: green duration expired.
REQ-012 count_done_y  output  1  one-cycle pulse: yellow duration expired.
REQ-013 remain  output  8  seconds remaining in the current phase (binary).
REQ-014 remain_bcd  output  8  remain as two BCD digits {tens, ones}; 0x99 when remain > 99.
REQ-015 req_err  output  1  high while count_g and count_y are both high.

Function
REQ-016 Requested phase SHALL be G if only count_g is high, Y if only count_y is high, else IDLE (both-high or both-low).
REQ-017 The block SHALL register the last sampled phase; an edge where the requested phase differs from it is a phase entry.
REQ-018 At phase entry into G/Y: remain <= duration of that phase, prescaler <= 0, done outputs <= 0.
REQ-019 At entry into IDLE: remain <= 0, prescaler <= 0; no ticks or done pulses while IDLE.
REQ-020 In an active phase (not entry), prescaler SHALL increment each cycle; when it equals TICK_DIV-1 it wraps to 0 and a tick occurs.
REQ-021 On a tick with remain > 1: remain decrements by 1.
REQ-022 On a tick with remain == 1: remain <= 0 and the phase's done output is high for exactly the next cycle.
REQ-023 Resulting latency: done asserted for one cycle after exactly N*TICK_DIV edges from the entry edge, N = loaded duration.
REQ-024 With remain == 0 in an active phase, remain holds 0, ticks are ignored, no further done pulses until the next entry.
REQ-025 count_done_g and count_done_y SHALL never be high in the same cycle.
REQ-026 cfg_we SHALL update the selected duration register at the edge; the new value applies from the next phase entry only.
REQ-027 A write on the same edge as a phase entry: the entry loads the old value.
REQ-028 cfg_data == 0 SHALL be stored as 1 (minimum one-second phase).
REQ-029 req_err is combinational from count_g & count_y; the block treats that case as IDLE per REQ-016.

Reset
REQ-030 On rst: remain = 0, prescaler = 0, last phase = IDLE, count_done_g = count_done_y = 0, green duration = G_DEFAULT, yellow duration = Y_DEFAULT.
REQ-031 Reset mid-phase SHALL abort the count; the first post-reset cycle with a request is a phase entry with full duration.

Structure
REQ-032 Shared package traffic_pkg SHALL hold the phase encoding (IDLE, G, Y) and the G_DEFAULT/Y_DEFAULT default constants.
REQ-033 Binary-to-BCD conversion SHALL be a combinational sub-module bin2bcd (8-bit in, 8-bit saturated BCD out).

Verification
REQ-034 TICK_DIV=4, defaults 3/2 (override), hold count_g -> count_done_g one-cycle pulse exactly 12 edges after entry; remain 3,2,1,0.
REQ-035 Close loop with the traffic controller, TICK_DIV=4, G=3, Y=2 -> phase lengths 12/8/12/8 cycles repeating; done pulses single-cycle.
REQ-036 Write G=5 mid-green -> current phase still expires at old value; next green lasts 20 cycles; write 0 -> phase lasts 4 cycles.
REQ-037 Drive count_g and count_y both high -> req_err = 1, remain = 0, no done pulses; release to count_y -> fresh entry, full yellow.
REQ-038 Assert rst 5 cycles into green -> all outputs at reset values next cycle; after release count restarts from full duration.
REQ-039 Green duration = 120 -> remain_bcd = 0x99 until remain = 99, then tracks 0x99, 0x98, ... 0x01, 0x00.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase timer: phase encoding and default durations.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_G    = 2'd1,
        PH_Y    = 2'd2
    } phase_e;

    localparam logic [7:0] G_DEFAULT = 8'd30;
    localparam logic [7:0] Y_DEFAULT = 8'd3;

endpackage

// File: rtl/bin2bcd.sv
// Combinational 8-bit binary to two-digit BCD, saturating at 99.
module bin2bcd (
    input  logic [7:0] bin,
    output logic [7:0] bcd
);

    always_comb begin
        bcd = 8'h99;
        if (bin <= 8'd99) begin
            bcd = {4'(bin / 8'd10), 4'(bin % 8'd10)};
        end
    end

endmodule

// File: rtl/traffic_timer.sv
// Per-phase countdown timer for a traffic controller: loads the phase duration on
// phase entry, counts whole seconds via a prescaler and pulses done on expiry.
module traffic_timer #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter logic [7:0]  G_DEFAULT = traffic_pkg::G_DEFAULT,
    parameter logic [7:0]  Y_DEFAULT = traffic_pkg::Y_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       count_g,
    input  logic       count_y,
    input  logic       cfg_we,
    input  logic       cfg_sel,
    input  logic [7:0] cfg_data,
    output logic       count_done_g,
    output logic       count_done_y,
    output logic [7:0] remain,
    output logic [7:0] remain_bcd,
    output logic       req_err
);

    import traffic_pkg::*;

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    phase_e          phase_q, phase_d, phase_req_c;
    logic            entry_c;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      remain_q, remain_d;
    logic [7:0]      dur_g_q, dur_g_d, dur_y_q, dur_y_d;
    logic [7:0]      cfg_val_c;
    logic            done_g_q, done_g_d, done_y_q, done_y_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_IDLE;
            presc_q  <= '0;
            remain_q <= '0;
            dur_g_q  <= G_DEFAULT;
            dur_y_q  <= Y_DEFAULT;
            done_g_q <= 1'b0;
            done_y_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            presc_q  <= presc_d;
            remain_q <= remain_d;
            dur_g_q  <= dur_g_d;
            dur_y_q  <= dur_y_d;
            done_g_q <= done_g_d;
            done_y_q <= done_y_d;
        end
    end

    always_comb begin
        phase_req_c = PH_IDLE;
        phase_d     = phase_q;
        presc_d     = presc_q;
        remain_d    = remain_q;
        dur_g_d     = dur_g_q;
        dur_y_d     = dur_y_q;
        done_g_d    = 1'b0;
        done_y_d    = 1'b0;
        cfg_val_c   = (cfg_data == 8'd0) ? 8'd1 : cfg_data;

        if (count_g && !count_y) begin
            phase_req_c = PH_G;
        end else if (count_y && !count_g) begin
            phase_req_c = PH_Y;
        end
        entry_c = (phase_req_c != phase_q);
        phase_d = phase_req_c;

        // Entry reloads from the registered durations, so a same-edge write is not seen yet.
        if (entry_c) begin
            presc_d = '0;
            case (phase_req_c)
                PH_G:    remain_d = dur_g_q;
                PH_Y:    remain_d = dur_y_q;
                default: remain_d = '0;
            endcase
        end else if (phase_q != PH_IDLE) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (remain_q > 8'd1) begin
                    remain_d = remain_q - 8'd1;
                end else if (remain_q == 8'd1) begin
                    remain_d = '0;
                    done_g_d = (phase_q == PH_G);
                    done_y_d = (phase_q == PH_Y);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (cfg_we && !cfg_sel) begin
            dur_g_d = cfg_val_c;
        end
        if (cfg_we && cfg_sel) begin
            dur_y_d = cfg_val_c;
        end
    end

    bin2bcd u_bin2bcd (
        .bin (remain_q),
        .bcd (remain_bcd)
    );

    assign remain       = remain_q;
    assign count_done_g = done_g_q;
    assign count_done_y = done_y_q;
    assign req_err      = count_g & count_y;

endmodule

// File: tb/tb_traffic_timer.sv
// Self-checking bench for traffic_timer against an elapsed-time reference model.
module tb_traffic_timer;

    localparam int T  = 4;
    localparam int DG = 3;
    localparam int DY = 2;

    typedef struct {
        logic       r;
        logic       g;
        logic       y;
        logic       we;
        logic       sel;
        logic [7:0] d;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       count_g = 1'b0;
    logic       count_y = 1'b0;
    logic       cfg_we = 1'b0;
    logic       cfg_sel = 1'b0;
    logic [7:0] cfg_data = 8'd0;
    logic       count_done_g, count_done_y, req_err;
    logic [7:0] remain, remain_bcd;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: phase, edges since entry, loaded duration, configured durations.
    int   m_phase, m_k, m_n, m_dg, m_dy, m_remain;
    logic m_done_g, m_done_y, m_req_err;

    stim_t sq[$];

    traffic_timer #(
        .TICK_DIV  (T),
        .G_DEFAULT (8'(DG)),
        .Y_DEFAULT (8'(DY))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .count_g      (count_g),
        .count_y      (count_y),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_data     (cfg_data),
        .count_done_g (count_done_g),
        .count_done_y (count_done_y),
        .remain       (remain),
        .remain_bcd   (remain_bcd),
        .req_err      (req_err)
    );

    always #5 clk = ~clk;

    task automatic model_step(input stim_t s);
        int req;
        m_req_err = s.g & s.y;
        if (s.r) begin
            m_phase = 0; m_k = 0; m_n = 0; m_dg = DG; m_dy = DY;
        end else begin
            req = (s.g && !s.y) ? 1 : ((s.y && !s.g) ? 2 : 0);
            if (req != m_phase) begin
                m_phase = req;
                m_k     = 0;
                m_n     = (req == 1) ? m_dg : ((req == 2) ? m_dy : 0);
            end else begin
                m_k++;
            end
            if (s.we && s.sel)  m_dy = (s.d == 8'd0) ? 1 : int'(s.d);
            if (s.we && !s.sel) m_dg = (s.d == 8'd0) ? 1 : int'(s.d);
        end
        m_remain = (m_phase == 0 || m_k / T >= m_n) ? 0 : m_n - m_k / T;
        m_done_g = !s.r && m_phase == 1 && m_k == m_n * T;
        m_done_y = !s.r && m_phase == 2 && m_k == m_n * T;
    endtask

    task automatic apply(input stim_t s);
        rst = s.r; count_g = s.g; count_y = s.y;
        cfg_we = s.we; cfg_sel = s.sel; cfg_data = s.d;
        @(posedge clk);
        model_step(s);
        @(negedge clk);
    endtask

    function automatic logic [18:0] expv();
        logic [7:0] r;
        logic [7:0] b;
        r = 8'(m_remain);
        b = (m_remain > 99) ? 8'h99 : {4'(m_remain / 10), 4'(m_remain % 10)};
        return {m_done_g, m_done_y, m_req_err, r, b};
    endfunction

    function automatic logic [18:0] obs();
        return {count_done_g, count_done_y, req_err, remain, remain_bcd};
    endfunction

    function automatic void push(input int n, input logic r, input logic g, input logic y,
                                 input logic we, input logic sel, input logic [7:0] d);
        stim_t s;
        s.r = r; s.g = g; s.y = y; s.we = we; s.sel = sel; s.d = d;
        for (int i = 0; i < n; i++) sq.push_back(s);
    endfunction

    task automatic test_reset();
        sq.delete();
        push(3, 1, 0, 0, 0, 0, 8'd0);
        foreach (sq[i]) begin
            apply(sq[i]);
            n_checks++;
            if (obs() !== expv()) $display("FAIL reset[%0d]: got %h, expected %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_green_hold();
        int done_at = -1;
        int pulses  = 0;
        sq.delete();
        push(1, 0, 0, 0, 0, 0, 8'd0);
        push(16, 0, 1, 0, 0, 0, 8'd0);
        foreach (sq[i]) begin
            apply(sq[i]);
            if (count_done_g) begin
                pulses++;
                if (done_at < 0) done_at = i - 1;
            end
            n_checks++;
            if (obs() !== expv()) $display("FAIL green_hold[%0d]: got %h, expected %h", i, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if (done_at !== 12 || pulses !== 1)
            $display("FAIL green_latency: got edge %0d pulses %0d, expected edge 12 pulses 1", done_at, pulses);
        else n_pass++;
    endtask

    task automatic test_closed_loop();
        logic ctl_y = 1'b0;
        stim_t s;
        int pulses = 0;
        s.r = 0; s.g = 0; s.y = 0; s.we = 0; s.sel = 0; s.d = 8'd0;
        apply(s);
        for (int i = 0; i < 120; i++) begin
            s.g = !ctl_y;
            s.y = ctl_y;
            apply(s);
            n_checks++;
            if (obs() !== expv()) $display("FAIL closed_loop[%0d]: got %h, expected %h", i, obs(), expv());
            else n_pass++;
            if (count_done_g) begin ctl_y = 1'b1; pulses++; end
            else if (count_done_y) begin ctl_y = 1'b0; pulses++; end
        end
        n_checks++;
        if (pulses < 8) $display("FAIL closed_loop_pulses: got %0d, expected at least 8", pulses);
        else n_pass++;
    endtask

    task automatic test_cfg_write();
        sq.delete();
        push(1, 0, 0, 0, 0, 0, 8'd0);
        push(5, 0, 1, 0, 0, 0, 8'd0);
        push(1, 0, 1, 0, 1, 0, 8'd5);
        push(10, 0, 1, 0, 0, 0, 8'd0);
        push(1, 0, 0, 0, 0, 0, 8'd0);
        push(22, 0, 1, 0, 0, 0, 8'd0);
        push(1, 0, 0, 0, 1, 0, 8'd0);
        push(6, 0, 1, 0, 0, 0, 8'd0);
        push(1, 0, 0, 0, 0, 0, 8'd0);
        push(1, 0, 0, 1, 1, 1, 8'd4);
        push(10, 0, 0, 1, 0, 0, 8'd0);
        push(1, 0, 0, 0, 0, 0, 8'd0);
        push(18, 0, 0, 1, 0, 0, 8'd0);
        foreach (sq[i]) begin
            apply(sq[i]);
            n_checks++;
            if (obs() !== expv()) $display("FAIL cfg_write[%0d]: got %h, expected %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_req_err();
        sq.delete();
        push(3, 0, 1, 0, 0, 0, 8'd0);
        push(10, 0, 1, 1, 0, 0, 8'd0);
        push(20, 0, 0, 1, 0, 0, 8'd0);
        foreach (sq[i]) begin
            apply(sq[i]);
            n_checks++;
            if (obs() !== expv()) $display("FAIL req_err[%0d]: got %h, expected %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        sq.delete();
        push(1, 0, 0, 0, 0, 0, 8'd0);
        push(5, 0, 1, 0, 0, 0, 8'd0);
        push(1, 1, 1, 0, 0, 0, 8'd0);
        push(22, 0, 1, 0, 0, 0, 8'd0);
        foreach (sq[i]) begin
            apply(sq[i]);
            n_checks++;
            if (obs() !== expv()) $display("FAIL reset_mid[%0d]: got %h, expected %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_bcd();
        sq.delete();
        push(1, 0, 0, 0, 1, 0, 8'd120);
        push(490, 0, 1, 0, 0, 0, 8'd0);
        foreach (sq[i]) begin
            apply(sq[i]);
            n_checks++;
            if (obs() !== expv()) $display("FAIL bcd[%0d]: got %h, expected %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        stim_t s;
        s.r = 0; s.g = 0; s.y = 0; s.we = 0; s.sel = 0; s.d = 8'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) s.g = 1'($urandom);
            if ($urandom_range(0, 39) == 0) s.y = 1'($urandom);
            s.we  = ($urandom_range(0, 31) == 0);
            s.sel = 1'($urandom);
            s.d   = 8'($urandom_range(0, 5));
            s.r   = ($urandom_range(0, 199) == 0);
            apply(s);
            n_checks++;
            if (obs() !== expv()) $display("FAIL random[%0d]: got %h, expected %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_green_hold();
        test_closed_loop();
        test_cfg_write();
        test_req_err();
        test_reset_mid();
        test_bcd();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
